// File: rtl/fadd_pkg.sv
// Shared types and defaults for the bit-serial adder slice.
package fadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } fsa_state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit combinational full adder, time-multiplexed by the serial adder.
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = x ^ y;
  assign s  = p ^ ci;
  assign co = (x & y) | (ci & p);

endmodule

// File: rtl/fadd_serial_adder.sv
// Bit-serial WIDTH-bit adder: accepts an operand pair, adds one bit per clock
// LSB first through a single full-adder cell, then holds the result until taken.
module fadd_serial_adder
  import fadd_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  fsa_state_t state_q, state_d;

  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;

  logic             fa_s;
  logic             fa_c;
  logic             last_bit;
  logic [WIDTH:0]   sum_shift;

  full_adder_cell u_fa (
    .x  (sa_q[0]),
    .y  (sb_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_c)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // New bit enters at the MSB; taking [WIDTH:1] keeps this legal for WIDTH=1.
  assign sum_shift = {fa_s, sum_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ADD;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sa_q    <= a;
            sb_q    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          sum_q   <= sum_shift[WIDTH:1];
          carry_q <= fa_c;
          cnt_q   <= cnt_q + CW'(1);
          if (last_bit) begin
            cout_q <= fa_c;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == ADD) || (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_fadd_serial_adder.sv
// Self-checking bench for fadd_serial_adder: directed cases plus randomized
// transactions compared against {cout,sum} = a + b + cin.
module tb_fadd_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  fadd_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + (W+1)'(c);
  endfunction

  // Starts and ends at a negedge with the DUT in IDLE.
  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                        input int stall, input bit noise);
    logic [W:0] exp;
    int cycles;
    exp = ref_add(ta, tb, tc);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < W + 4) begin
      check("in_ready_add", in_ready, 0);
      if (noise) begin
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        in_valid = 1'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      cycles++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("latency", cycles, W);
    check("sum", sum, exp[W-1:0]);
    check("cout", cout, exp[W]);
    check("busy_done", busy, 1);
    check("in_ready_done", in_ready, 0);
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom);
      @(posedge clk); @(negedge clk);
      check("hold_valid", out_valid, 1);
      check("hold_sum", sum, exp[W-1:0]);
      check("hold_cout", cout, exp[W]);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
    check("release_busy", busy, 0);
  endtask

  initial begin
    int saw;
    int nres;
    logic [W-1:0] res_sum [2];
    logic         res_cout[2];
    int           res_idx [2];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);

    do_txn(8'h12, 8'h34, 1'b0, 0, 1'b0);
    do_txn(8'hFF, 8'h01, 1'b0, 0, 1'b0);
    do_txn(8'h5A, 8'hA5, 1'b1, 0, 1'b0);
    do_txn(8'h80, 8'h80, 1'b0, 5, 1'b0);
    do_txn(8'h3C, 8'h41, 1'b1, 1, 1'b1);

    // Reset after three add edges: nothing may surface afterwards.
    a = 8'hC3; b = 8'h7E; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_busy", busy, 0);
    saw = 0;
    repeat (W + 3) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) saw++;
    end
    check("midrst_no_result", saw, 0);

    // Back-to-back with in_valid and out_ready held high.
    nres = 0;
    a = 8'h01; b = 8'h02; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    check("b2b_in_ready", in_ready, 1);
    @(posedge clk); @(negedge clk);
    for (int k = 1; k <= 2 * W + 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid && nres < 2) begin
        res_sum[nres] = sum; res_cout[nres] = cout; res_idx[nres] = k;
        if (nres == 0) begin
          a = 8'hF0; b = 8'h0F; cin = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
        nres++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", nres, 2);
    if (nres == 2) begin
      check("b2b_sum0", res_sum[0], 8'h03);
      check("b2b_cout0", res_cout[0], 0);
      check("b2b_idx0", res_idx[0], W);
      check("b2b_sum1", res_sum[1], 8'h00);
      check("b2b_cout1", res_cout[1], 1);
      check("b2b_idx1", res_idx[1], 2 * W + 2);
    end
    repeat (2) begin @(posedge clk); @(negedge clk); end

    for (int t = 0; t < 30; t++) begin
      do_txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
